// File: rtl/floating_point_pkg.sv
// Shared constants and FSM state type for the binary32 divider.
package floating_point_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int BIAS      = 127;
    localparam int DIV_STEPS = 25;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORMALIZE,
        DONE
    } state_t;

endpackage

// File: rtl/mantissa_restoring_divider.sv
// Iterative restoring divider producing floor(dividend*2^24/divisor), one bit per step.
module mantissa_restoring_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [23:0] dividend_i,
    input  logic [23:0] divisor_i,
    output logic [24:0] quotient_o,
    output logic [24:0] remainder_o
);

    logic [24:0] rem_q;
    logic [24:0] rem_d;
    logic [23:0] div_q;
    logic [24:0] quo_q;
    logic [24:0] quo_d;
    logic        geDivisor;
    logic [24:0] diff;

    // The dividend occupies the partial remainder directly; the 2^24 scale comes from the left shifts.
    assign geDivisor = (rem_q >= {1'b0, div_q});
    assign diff      = geDivisor ? (rem_q - {1'b0, div_q}) : rem_q;
    assign rem_d     = diff << 1;
    assign quo_d     = {quo_q[23:0], geDivisor};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
        end else if (load_i) begin
            rem_q <= {1'b0, dividend_i};
            div_q <= divisor_i;
            quo_q <= '0;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/floating_point_divider.sv
// IEEE-754 binary32 divider: special cases resolve in one cycle, normal operands take 27 cycles.
module floating_point_divider
    import floating_point_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quotient,
    output logic        busy,
    output logic        done,
    output logic        infinity,
    output logic        NAN,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    state_t             state_q;
    logic [4:0]         count_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [31:0]        quotient_q;
    logic               done_q;
    logic               inf_q;
    logic               nan_q;
    logic               ovf_q;
    logic               unf_q;
    logic               dbz_q;

    logic [EXP_W-1:0]   expA;
    logic [EXP_W-1:0]   expB;
    logic [FRAC_W-1:0]  fracA;
    logic [FRAC_W-1:0]  fracB;
    logic               aNan, bNan, aInf, bInf, aZero, bZero;
    logic               signRes;
    logic [9:0]         expInit;

    logic               special;
    logic [31:0]        specQ;
    logic               specNan, specInf, specDbz;

    logic               divLoad;
    logic               divStep;
    logic [24:0]        divQuo;
    logic [24:0]        remainder_unused;

    logic signed [9:0]  normExp;
    logic [FRAC_W-1:0]  normFrac;
    logic               normOvf;
    logic               normUnf;

    assign expA  = a[30:23];
    assign expB  = b[30:23];
    assign fracA = a[FRAC_W-1:0];
    assign fracB = b[FRAC_W-1:0];

    // Denormals have exp==0 and are folded into zero along with true zeros.
    assign aNan  = (&expA) & (|fracA);
    assign bNan  = (&expB) & (|fracB);
    assign aInf  = (&expA) & ~(|fracA);
    assign bInf  = (&expB) & ~(|fracB);
    assign aZero = ~(|expA);
    assign bZero = ~(|expB);

    assign signRes = a[31] ^ b[31];
    assign expInit = {2'b00, expA} - {2'b00, expB} + 10'(BIAS);

    always_comb begin
        special = 1'b1;
        specQ   = '0;
        specNan = 1'b0;
        specInf = 1'b0;
        specDbz = 1'b0;
        if (aNan | bNan | (aZero & bZero) | (aInf & bInf)) begin
            specQ   = QNAN;
            specNan = 1'b1;
        end else if (aInf) begin
            specQ   = {signRes, POS_INF[30:0]};
            specInf = 1'b1;
        end else if (bZero) begin
            specQ   = {signRes, POS_INF[30:0]};
            specInf = 1'b1;
            specDbz = 1'b1;
        end else if (bInf | aZero) begin
            specQ   = {signRes, 31'b0};
        end else begin
            special = 1'b0;
        end
    end

    assign divLoad = (state_q == IDLE) && start && !special;
    assign divStep = (state_q == DIVIDE);

    mantissa_restoring_divider u_mantissa (
        .clk         (clk),
        .rst         (rst),
        .load_i      (divLoad),
        .step_i      (divStep),
        .dividend_i  ({1'b1, fracA}),
        .divisor_i   ({1'b1, fracB}),
        .quotient_o  (divQuo),
        .remainder_o (remainder_unused)
    );

    // Mantissa ratio lies in (0.5, 2): a clear top bit means one position of left shift.
    always_comb begin
        if (divQuo[24]) begin
            normFrac = divQuo[23:1];
            normExp  = exp_q;
        end else begin
            normFrac = divQuo[22:0];
            normExp  = exp_q - 10'sd1;
        end
    end

    assign normOvf = (normExp >= 10'sd255);
    assign normUnf = (normExp <= 10'sd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            quotient_q <= '0;
            done_q     <= 1'b0;
            inf_q      <= 1'b0;
            nan_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= signRes;
                        exp_q   <= expInit;
                        count_q <= '0;
                        inf_q   <= 1'b0;
                        nan_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        dbz_q   <= 1'b0;
                        if (special) begin
                            quotient_q <= specQ;
                            nan_q      <= specNan;
                            inf_q      <= specInf;
                            dbz_q      <= specDbz;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (count_q == 5'(DIV_STEPS - 1)) begin
                        count_q <= '0;
                        state_q <= NORMALIZE;
                    end else begin
                        count_q <= count_q + 5'd1;
                    end
                end
                NORMALIZE: begin
                    if (normOvf) begin
                        quotient_q <= {sign_q, POS_INF[30:0]};
                        ovf_q      <= 1'b1;
                        inf_q      <= 1'b1;
                    end else if (normUnf) begin
                        quotient_q <= {sign_q, 31'b0};
                        unf_q      <= 1'b1;
                    end else begin
                        quotient_q <= {sign_q, normExp[7:0], normFrac};
                    end
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign infinity    = inf_q;
    assign NAN         = nan_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/floating_point_divider.md
FLOATING_POINT_DIVIDER -- requirements
Module: floating_point_divider

Interface
REQ-001 SHALL have no parameters; the format is fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  32  dividend, binary32; sampled with accepted start.
REQ-006 b  input  32  divisor, binary32; sampled with accepted start.
REQ-007 quotient  output  32  result a/b, binary32; registered.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; quotient and flags valid from this cycle.
REQ-010 infinity, NAN, overflow, underflow, div_by_zero  output  1 each  registered result flags.

Function
REQ-011 SHALL implement the FSM IDLE -> DIVIDE -> NORMALIZE -> DONE -> IDLE; start is accepted only when state is IDLE and start=1 (edge 0).
REQ-012 Start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-013 On acceptance, SHALL latch a and b, and clear all flags.
REQ-014 Denormal inputs (exp=0, frac!=0) SHALL be treated as signed zero.
REQ-015 Result sign SHALL be a[31] XOR b[31] for all non-NaN results.
REQ-016 Special cases SHALL be resolved at edge 0, go directly to DONE, and assert done in the following cycle. The cases are:
- any NaN input, 0/0 or inf/inf: quotient 0x7FC00000, NAN=1.
- finite nonzero/0: signed inf, infinity=1, div_by_zero=1.
- inf/finite: signed inf, infinity=1.
- finite/inf or 0/nonzero-finite: signed zero.
REQ-017 Normal path: Ma={1,a[22:0]}, Mb={1,b[22:0]}; DIVIDE SHALL run a restoring division for exactly 25 cycles (edges 1..25), one quotient bit per cycle, MSB first, giving q=floor(Ma*2^24/Mb), 25 bits.
REQ-018 The exponent SHALL be computed as a 10-bit signed value E=ea-eb+127.
REQ-019 NORMALIZE (edge 26) SHALL proceed as follows:
- if q[24]=1: frac=q[23:1], E unchanged.
- else: frac=q[22:0], E=E-1.
- Rounding is truncation (round toward zero).
REQ-020 If the final E>=255: quotient = signed inf, overflow=1, infinity=1.
REQ-021 If the final E<=0: quotient = signed zero, underflow=1; no denormal output.
REQ-022 Normal-path done SHALL be high in the cycle after edge 26; latency is 27 cycles from acceptance.
REQ-023 After done, quotient and flags SHALL hold until the next accepted start.
REQ-024 The done pulse SHALL last exactly one cycle; the FSM returns to IDLE at the next edge and may accept start in that same IDLE cycle.

Reset
REQ-025 rst=1 SHALL force the following immediately and asynchronously, including mid-operation:
- state IDLE, iteration counter 0.
- quotient=0, done=0, busy=0, all flags 0.
REQ-026 An operation interrupted by reset SHALL be discarded and never produce done.

Structure
REQ-027 Package floating_point_pkg SHALL hold:
- EXP_W=8, FRAC_W=23, BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
- the FSM state enum.
REQ-028 The iterative mantissa datapath SHALL be the sub-module mantissa_restoring_divider: load, step, 25-bit quotient, and remainder.

Verification
REQ-029 0x45701440 (3841.265625) / 0x42348000 (45.125) -> quotient 0x42AA4000 (85.125), all flags 0, done exactly 27 cycles after start accepted.
REQ-030 0xC2098000 (-34.375) / 0x40C80000 (6.25) -> 0xC0B00000 (-5.5); 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated 1/3).
REQ-031 0x40A00000 / 0x00000000 -> 0x7F800000, infinity=1, div_by_zero=1, done 1 cycle after acceptance; 0/0 -> 0x7FC00000, NAN=1.
REQ-032 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow=1, infinity=1; 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
REQ-033 Pulse start with new operands at cycle 10 of a busy operation -> first result unchanged, only one done.
REQ-034 Assert rst at cycle 12 of DIVIDE -> all outputs 0 immediately, no done; a fresh start afterwards yields the correct result.
